zap_btb_predict: RTL and testbench

- Parametrised branch target buffer and direction predictor between fetch and decode.
- Each entry holds a valid bit, partial tag, saturating counter and target address.
- Registers the fetch bundle with a taken/target prediction, and learns from ALU resolution feedback.
- The table is cleared by a hardware sweep after reset.

---
 rtl/zap_bp_pkg.sv | 40 ++++
 rtl/zap_btb_ram.sv | 60 ++++++
 rtl/zap_btb_predict.sv | 217 +++++++++++++++++++++
 tb/tb_zap_btb_predict.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zap_bp_pkg
//  Description : Shared types, clear values and saturating-counter helpers
//                for the ZAP branch target buffer / direction predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package zap_bp_pkg;

    // Predictor controller states: table sweep after reset, then normal use.
    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    // Values loaded into the fetch/decode register on any flush.
    localparam logic [31:0] CLR_INST       = 32'd0;
    localparam logic        CLR_VAL        = 1'b0;
    localparam logic        CLR_ABT        = 1'b0;
    localparam logic [31:0] CLR_PC         = 32'd0;
    localparam logic [31:0] CLR_PC_PLUS_8  = 32'd8;
    localparam logic        CLR_TAKEN      = 1'b0;
    localparam logic        CLR_HIT        = 1'b0;
    localparam logic [31:0] CLR_TARGET     = 32'd0;

    // Increment a ctr_w-bit counter, sticking at its all-ones maximum.
    function automatic logic [31:0] ctr_sat_inc(input logic [31:0] ctr,
                                                input int          ctr_w);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        return (ctr >= max_v) ? max_v : ctr + 32'd1;
    endfunction

    // Decrement a counter, sticking at zero.
    function automatic logic [31:0] ctr_sat_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zap_btb_ram.sv
`default_nettype none
// ============================================================================
//  Module      : zap_btb_ram
//  Description : BTB storage: valid/tag/counter/target arrays with one
//                synchronous write port and two asynchronous read ports
//                (fetch lookup and resolution lookup).
//  Revision    : 1.0 - initial release
// ============================================================================
module zap_btb_ram #(
    parameter  int ENTRIES = 512,
    parameter  int TAG_W   = 8,
    parameter  int CTR_W   = 2,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [CTR_W-1:0] wr_ctr,
    input  logic [31:0]      wr_target,
    input  logic [IDX_W-1:0] rd_idx_a,
    output logic             rd_valid_a,
    output logic [TAG_W-1:0] rd_tag_a,
    output logic [CTR_W-1:0] rd_ctr_a,
    output logic [31:0]      rd_target_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic             rd_valid_b,
    output logic [TAG_W-1:0] rd_tag_b,
    output logic [CTR_W-1:0] rd_ctr_b,
    output logic [31:0]      rd_target_b
);

    logic             valid_mem  [ENTRIES];
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    logic [CTR_W-1:0] ctr_mem    [ENTRIES];
    logic [31:0]      target_mem [ENTRIES];

    // Single write port; no reset, contents are initialised by the sweep.
    always_ff @(posedge i_clk) begin
        if (we) begin
            valid_mem[wr_idx]  <= wr_valid;
            tag_mem[wr_idx]    <= wr_tag;
            ctr_mem[wr_idx]    <= wr_ctr;
            target_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_valid_a  = valid_mem[rd_idx_a];
    assign rd_tag_a    = tag_mem[rd_idx_a];
    assign rd_ctr_a    = ctr_mem[rd_idx_a];
    assign rd_target_a = target_mem[rd_idx_a];

    assign rd_valid_b  = valid_mem[rd_idx_b];
    assign rd_tag_b    = tag_mem[rd_idx_b];
    assign rd_ctr_b    = ctr_mem[rd_idx_b];
    assign rd_target_b = target_mem[rd_idx_b];

endmodule
`default_nettype wire

// File: rtl/zap_btb_predict.sv
`default_nettype none
// ============================================================================
//  Module      : zap_btb_predict
//  Description : Fetch-to-decode register with BTB lookup and 2-bit style
//                direction prediction; learns from ALU branch resolution and
//                sweeps the table clear after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module zap_btb_predict
    import zap_bp_pkg::*;
#(
    parameter int ENTRIES = 512,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_val,
    input  logic        i_abt,
    input  logic [31:0] i_pc_plus_8,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    output logic [31:0] o_inst_ff,
    output logic        o_val_ff,
    output logic        o_abt_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [31:0] o_pc_ff,
    output logic        o_taken_ff,
    output logic        o_hit_ff,
    output logic [31:0] o_target_ff,
    output logic        o_init_busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
    localparam logic [CTR_W-1:0] WEAK_TAKE = CTR_W'(1) << (CTR_W - 1);

    bp_state_t        state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;

    // Bit 0 is dropped so ARM and Thumb fetches share entries.
    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;

    logic             f_valid, u_valid;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic [CTR_W-1:0] f_ctr, u_ctr;
    logic [31:0]      f_target, u_target;

    logic             we;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [CTR_W-1:0] wr_ctr;
    logic [31:0]      wr_target;

    logic             look_hit, look_taken, upd_hit;
    logic [31:0]      look_target;
    logic             unused_pc_bits;

    assign fetch_idx = i_pc[IDX_W:1];
    assign fetch_tag = i_pc[IDX_W+TAG_W:IDX_W+1];
    assign upd_idx   = i_upd_pc[IDX_W:1];
    assign upd_tag   = i_upd_pc[IDX_W+TAG_W:IDX_W+1];

    assign unused_pc_bits = ^{i_pc[0], i_pc[31:IDX_W+TAG_W+1],
                              i_upd_pc[0], i_upd_pc[31:IDX_W+TAG_W+1]};

    zap_btb_ram #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CTR_W   (CTR_W)
    ) u_ram (
        .i_clk       (i_clk),
        .we          (we),
        .wr_idx      (wr_idx),
        .wr_valid    (wr_valid),
        .wr_tag      (wr_tag),
        .wr_ctr      (wr_ctr),
        .wr_target   (wr_target),
        .rd_idx_a    (fetch_idx),
        .rd_valid_a  (f_valid),
        .rd_tag_a    (f_tag),
        .rd_ctr_a    (f_ctr),
        .rd_target_a (f_target),
        .rd_idx_b    (upd_idx),
        .rd_valid_b  (u_valid),
        .rd_tag_b    (u_tag),
        .rd_ctr_b    (u_ctr),
        .rd_target_b (u_target)
    );

    // Fetch lookup reads the table before any same-cycle write lands.
    assign look_hit    = (state == BP_RUN) && f_valid && (f_tag == fetch_tag);
    assign look_taken  = look_hit && f_ctr[CTR_W-1];
    assign look_target = look_hit ? f_target : CLR_TARGET;
    assign upd_hit     = u_valid && (u_tag == upd_tag);
    assign o_init_busy = (state == BP_INIT);

    // Controller state and sweep pointer; reset always restarts the sweep.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= BP_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state plus the single table write: sweep clear or training.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        we        = 1'b0;
        wr_idx    = upd_idx;
        wr_valid  = 1'b0;
        wr_tag    = upd_tag;
        wr_ctr    = '0;
        wr_target = i_upd_target;
        if (!i_reset) begin
            case (state)
                BP_INIT: begin
                    we        = 1'b1;
                    wr_idx    = ptr;
                    wr_tag    = '0;
                    wr_target = 32'd0;
                    ptr_nxt   = ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state_nxt = BP_RUN;
                        ptr_nxt   = '0;
                    end
                end
                BP_RUN: begin
                    if (i_upd_valid && !i_data_stall) begin
                        if (upd_hit) begin
                            we       = 1'b1;
                            wr_valid = 1'b1;
                            if (i_upd_taken) begin
                                wr_ctr = CTR_W'(ctr_sat_inc(32'(u_ctr), CTR_W));
                            end else begin
                                wr_ctr    = CTR_W'(ctr_sat_dec(32'(u_ctr)));
                                wr_target = u_target;
                            end
                        end else if (i_upd_taken) begin
                            we       = 1'b1;
                            wr_valid = 1'b1;
                            wr_ctr   = WEAK_TAKE;
                        end
                    end
                end
                default: begin
                    state_nxt = BP_INIT;
                    ptr_nxt   = '0;
                end
            endcase
        end
    end

    // Fetch/decode register: flush and stall priority, then load.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear_from_writeback) begin
            o_inst_ff      <= CLR_INST;
            o_val_ff       <= CLR_VAL;
            o_abt_ff       <= CLR_ABT;
            o_pc_plus_8_ff <= CLR_PC_PLUS_8;
            o_pc_ff        <= CLR_PC;
            o_taken_ff     <= CLR_TAKEN;
            o_hit_ff       <= CLR_HIT;
            o_target_ff    <= CLR_TARGET;
        end else if (i_data_stall) begin
            o_val_ff <= o_val_ff;
        end else if (i_clear_from_alu) begin
            o_inst_ff      <= CLR_INST;
            o_val_ff       <= CLR_VAL;
            o_abt_ff       <= CLR_ABT;
            o_pc_plus_8_ff <= CLR_PC_PLUS_8;
            o_pc_ff        <= CLR_PC;
            o_taken_ff     <= CLR_TAKEN;
            o_hit_ff       <= CLR_HIT;
            o_target_ff    <= CLR_TARGET;
        end else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) begin
            o_val_ff <= o_val_ff;
        end else if (i_clear_from_decode) begin
            o_inst_ff      <= CLR_INST;
            o_val_ff       <= CLR_VAL;
            o_abt_ff       <= CLR_ABT;
            o_pc_plus_8_ff <= CLR_PC_PLUS_8;
            o_pc_ff        <= CLR_PC;
            o_taken_ff     <= CLR_TAKEN;
            o_hit_ff       <= CLR_HIT;
            o_target_ff    <= CLR_TARGET;
        end else begin
            o_inst_ff      <= i_inst;
            o_val_ff       <= i_val;
            o_abt_ff       <= i_abt;
            o_pc_plus_8_ff <= i_pc_plus_8;
            o_pc_ff        <= i_pc;
            o_taken_ff     <= look_taken;
            o_hit_ff       <= look_hit;
            o_target_ff    <= look_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zap_btb_predict.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zap_btb_predict
//  Description : Self-checking bench for zap_btb_predict: reference model of
//                the predictor table and output register, literal vector
//                table for flush/stall priority, directed corner sequences
//                and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_btb_predict;

    localparam int ENTRIES = 512;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int CTR_MAX = (1 << CTR_W) - 1;
    localparam int CTR_MID = 1 << (CTR_W - 1);

    logic        i_clk = 1'b0;
    logic        i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode;
    logic        i_clear_from_decode;
    logic [31:0] i_pc, i_inst, i_pc_plus_8, i_upd_pc, i_upd_target;
    logic        i_val, i_abt, i_upd_valid, i_upd_taken;
    logic [31:0] o_inst_ff, o_pc_plus_8_ff, o_pc_ff, o_target_ff;
    logic        o_val_ff, o_abt_ff, o_taken_ff, o_hit_ff, o_init_busy;

    always #5 i_clk = ~i_clk;

    zap_btb_predict #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_stall_from_shifter   (i_stall_from_shifter),
        .i_stall_from_issue     (i_stall_from_issue),
        .i_stall_from_decode    (i_stall_from_decode),
        .i_clear_from_decode    (i_clear_from_decode),
        .i_pc                   (i_pc),
        .i_inst                 (i_inst),
        .i_val                  (i_val),
        .i_abt                  (i_abt),
        .i_pc_plus_8            (i_pc_plus_8),
        .i_upd_valid            (i_upd_valid),
        .i_upd_pc               (i_upd_pc),
        .i_upd_taken            (i_upd_taken),
        .i_upd_target           (i_upd_target),
        .o_inst_ff              (o_inst_ff),
        .o_val_ff               (o_val_ff),
        .o_abt_ff               (o_abt_ff),
        .o_pc_plus_8_ff         (o_pc_plus_8_ff),
        .o_pc_ff                (o_pc_ff),
        .o_taken_ff             (o_taken_ff),
        .o_hit_ff               (o_hit_ff),
        .o_target_ff            (o_target_ff),
        .o_init_busy            (o_init_busy)
    );

    // ---------------- reference model ----------------
    bit          m_valid  [ENTRIES];
    int          m_tag    [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          init_left = 0;
    bit          model_known = 0;

    logic [31:0] e_inst, e_pc, e_pc8, e_target;
    logic        e_val, e_abt, e_taken, e_hit;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc / 32'd2) % 32'(ENTRIES));
    endfunction

    function automatic int pc_tag(input logic [31:0] pc);
        return int'((pc / 32'(2 * ENTRIES)) % 32'(1 << TAG_W));
    endfunction

    task automatic model_clear_outputs();
        e_inst = 0; e_val = 0; e_abt = 0; e_pc = 0; e_pc8 = 32'd8;
        e_taken = 0; e_hit = 0; e_target = 0;
    endtask

    // Advance one clock: predict from current inputs, then compare.
    task automatic step();
        int fi, ui;
        bit fhit, uhit;
        fi   = pc_idx(i_pc);
        fhit = (init_left == 0) && m_valid[fi] && (m_tag[fi] == pc_tag(i_pc));
        if (i_reset || i_clear_from_writeback) model_clear_outputs();
        else if (i_data_stall) begin end
        else if (i_clear_from_alu) model_clear_outputs();
        else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) begin end
        else if (i_clear_from_decode) model_clear_outputs();
        else begin
            e_inst = i_inst; e_val = i_val; e_abt = i_abt; e_pc = i_pc; e_pc8 = i_pc_plus_8;
            e_hit = fhit;
            e_taken = fhit && (m_ctr[fi] >= CTR_MID);
            e_target = fhit ? m_target[fi] : 32'd0;
        end
        if (!i_reset && init_left == 0 && i_upd_valid && !i_data_stall) begin
            ui   = pc_idx(i_upd_pc);
            uhit = m_valid[ui] && (m_tag[ui] == pc_tag(i_upd_pc));
            if (uhit && i_upd_taken) begin
                m_ctr[ui] = (m_ctr[ui] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[ui] + 1;
                m_target[ui] = i_upd_target;
            end else if (uhit) begin
                m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end else if (i_upd_taken) begin
                m_valid[ui] = 1; m_tag[ui] = pc_tag(i_upd_pc);
                m_ctr[ui] = CTR_MID; m_target[ui] = i_upd_target;
            end
        end
        if (i_reset) begin
            init_left = ENTRIES;
            model_known = 1;
        end else if (init_left > 0) begin
            init_left--;
            if (init_left == 0)
                for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 0; m_ctr[k] = 0; end
        end
        @(posedge i_clk);
        #1;
        if (model_known) begin
            check("inst", o_inst_ff, e_inst);
            check("val", 32'(o_val_ff), 32'(e_val));
            check("abt", 32'(o_abt_ff), 32'(e_abt));
            check("pc", o_pc_ff, e_pc);
            check("pc_plus_8", o_pc_plus_8_ff, e_pc8);
            check("hit", 32'(o_hit_ff), 32'(e_hit));
            check("taken", 32'(o_taken_ff), 32'(e_taken));
            check("target", o_target_ff, e_target);
            check("init_busy", 32'(o_init_busy), 32'(init_left > 0));
        end
    endtask

    task automatic quiet();
        i_reset = 0; i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_stall_from_shifter = 0; i_stall_from_issue = 0; i_stall_from_decode = 0;
        i_clear_from_decode = 0; i_upd_valid = 0; i_upd_taken = 0;
        i_upd_pc = 0; i_upd_target = 0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        i_pc = pc; i_pc_plus_8 = pc + 32'd8; i_val = 1; i_abt = 0; i_inst = $urandom;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        i_upd_valid = 1; i_upd_pc = pc; i_upd_taken = tk; i_upd_target = tgt;
    endtask

    // Train 0x100 once, then probe it and compare against literal values.
    task automatic train_probe(input logic tk, input logic [31:0] tgt,
                               input logic exp_taken, input logic [31:0] exp_tgt, input int id);
        quiet(); fetch(32'h180); upd(32'h100, tk, tgt); step();
        quiet(); fetch(32'h100); step();
        check($sformatf("sat%0d_hit", id), 32'(o_hit_ff), 32'd1);
        check($sformatf("sat%0d_taken", id), 32'(o_taken_ff), 32'(exp_taken));
        check($sformatf("sat%0d_target", id), o_target_ff, exp_tgt);
    endtask

    // Wait for the sweep to end; return the number of busy samples seen.
    task automatic sweep_len(input bit inject_upd, output int busy_cnt, output bit any_hit);
        busy_cnt = o_init_busy ? 1 : 0;
        any_hit  = 0;
        for (int c = 0; c < 2000 && o_init_busy; c++) begin
            quiet();
            fetch(32'h100);
            if (inject_upd && c == 10) upd(32'h100, 1'b1, 32'h2000);
            step();
            if (o_init_busy) busy_cnt++;
            any_hit |= o_hit_ff;
        end
    endtask

    typedef struct {
        logic        wb, ds, alu, shf, iss, dst, dcl;
        logic        exp_val;
        logic [31:0] exp_pc, exp_pc8;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  busy_cnt;
        bit  any_hit;
        logic [31:0] pool [6];

        vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 1'b0, 32'h0,    32'h8};
        vecs[1] = '{0, 1, 0, 0, 0, 0, 0, 1'b1, 32'h4000, 32'h4008};
        vecs[2] = '{0, 1, 1, 0, 0, 0, 1, 1'b1, 32'h4000, 32'h4008};
        vecs[3] = '{0, 0, 1, 0, 0, 0, 0, 1'b0, 32'h0,    32'h8};
        vecs[4] = '{0, 0, 1, 1, 0, 0, 0, 1'b0, 32'h0,    32'h8};
        vecs[5] = '{0, 0, 0, 1, 0, 0, 1, 1'b1, 32'h4000, 32'h4008};
        vecs[6] = '{0, 0, 0, 0, 1, 0, 0, 1'b1, 32'h4000, 32'h4008};
        vecs[7] = '{0, 0, 0, 0, 0, 1, 1, 1'b1, 32'h4000, 32'h4008};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 1, 1'b0, 32'h0,    32'h8};
        vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h5000, 32'h5008};

        quiet();
        fetch(32'h0);

        // Reset for one cycle, then the sweep with a dropped update.
        i_reset = 1; step(); i_reset = 0;
        check("reset_val", 32'(o_val_ff), 32'd0);
        check("reset_pc8", o_pc_plus_8_ff, 32'd8);
        sweep_len(1'b1, busy_cnt, any_hit);
        check("sweep_busy_len", 32'(busy_cnt), 32'd512);
        check("sweep_hit", 32'(any_hit), 32'd0);
        quiet(); fetch(32'h100); step();
        check("lost_update_hit", 32'(o_hit_ff), 32'd0);

        // Allocation, with read-before-write on the same cycle.
        quiet(); fetch(32'h100); upd(32'h100, 1'b1, 32'h2000); step();
        check("alloc_rbw_hit", 32'(o_hit_ff), 32'd0);
        quiet(); fetch(32'h100); step();
        check("alloc_hit", 32'(o_hit_ff), 32'd1);
        check("alloc_taken", 32'(o_taken_ff), 32'd1);
        check("alloc_target", o_target_ff, 32'h2000);

        // Saturation walk: 2->1->0->0->1->2->3->3->2->1.
        train_probe(1'b0, 32'hDEAD, 1'b0, 32'h2000, 0);
        train_probe(1'b0, 32'hDEAD, 1'b0, 32'h2000, 1);
        train_probe(1'b0, 32'hDEAD, 1'b0, 32'h2000, 2);
        train_probe(1'b1, 32'h3000, 1'b0, 32'h3000, 3);
        train_probe(1'b1, 32'h3000, 1'b1, 32'h3000, 4);
        train_probe(1'b1, 32'h3000, 1'b1, 32'h3000, 5);
        train_probe(1'b1, 32'h3000, 1'b1, 32'h3000, 6);
        train_probe(1'b0, 32'hBEEF, 1'b1, 32'h3000, 7);
        train_probe(1'b0, 32'hBEEF, 1'b0, 32'h3000, 8);

        // Tag alias misses; Thumb address shares the entry.
        quiet(); fetch(32'h100 + 32'(ENTRIES * 2)); step();
        check("alias_hit", 32'(o_hit_ff), 32'd0);
        check("alias_target", o_target_ff, 32'd0);
        quiet(); fetch(32'h101); step();
        check("thumb_hit", 32'(o_hit_ff), 32'd1);
        check("thumb_target", o_target_ff, 32'h3000);

        // Flush / stall priority table.
        for (int v = 0; v < 10; v++) begin
            quiet(); fetch(32'h4000); step();
            fetch(32'h5000);
            i_clear_from_writeback = vecs[v].wb; i_data_stall = vecs[v].ds;
            i_clear_from_alu = vecs[v].alu; i_stall_from_shifter = vecs[v].shf;
            i_stall_from_issue = vecs[v].iss; i_stall_from_decode = vecs[v].dst;
            i_clear_from_decode = vecs[v].dcl;
            step();
            check($sformatf("vec%0d_val", v), 32'(o_val_ff), 32'(vecs[v].exp_val));
            check($sformatf("vec%0d_pc", v), o_pc_ff, vecs[v].exp_pc);
            check($sformatf("vec%0d_pc8", v), o_pc_plus_8_ff, vecs[v].exp_pc8);
        end

        // Data stall blocks an update to a live entry.
        quiet(); fetch(32'h4000); step();
        fetch(32'h100); i_data_stall = 1; upd(32'h100, 1'b1, 32'h7777); step();
        check("ds_hold_pc", o_pc_ff, 32'h4000);
        quiet(); fetch(32'h100); step();
        check("ds_table_target", o_target_ff, 32'h3000);

        // Reset in the middle of the sweep restarts it.
        quiet(); i_reset = 1; step(); i_reset = 0;
        for (int c = 0; c < 99; c++) begin quiet(); fetch(32'h100); step(); end
        quiet(); i_reset = 1; step(); i_reset = 0;
        sweep_len(1'b0, busy_cnt, any_hit);
        check("midsweep_busy_len", 32'(busy_cnt), 32'd512);

        // Randomized traffic against the model.
        pool = '{32'h100, 32'h104, 32'h108, 32'h500, 32'h904, 32'h3FE};
        for (int c = 0; c < 3000; c++) begin
            quiet();
            fetch(pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 1)));
            i_val = 1'($urandom); i_abt = ($urandom_range(0, 7) == 0);
            i_clear_from_writeback = ($urandom_range(0, 15) == 0);
            i_data_stall           = ($urandom_range(0, 7) == 0);
            i_clear_from_alu       = ($urandom_range(0, 15) == 0);
            i_stall_from_shifter   = ($urandom_range(0, 15) == 0);
            i_stall_from_issue     = ($urandom_range(0, 15) == 0);
            i_stall_from_decode    = ($urandom_range(0, 15) == 0);
            i_clear_from_decode    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1)
                upd(pool[$urandom_range(0, 5)], 1'($urandom), $urandom & 32'hFFFF_FFFE);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
